// File: rtl/xres_conditioner.sv
// External reset pin conditioner: synchronises and debounces the pad XRES level,
// counts rejected pulses, and sequences core then peripheral reset release.
module xres_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 16,
  parameter int MIN_ASSERT  = 64,
  parameter int STAGE_DELAY = 8,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       xres_n_in,
  input  logic       filt_en,
  input  logic       xres_seen_clr,
  output logic       core_rst_n,
  output logic       periph_rst_n,
  output logic       xres_seen,
  output logic [7:0] glitch_cnt,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_HOLD  = 2'b00,
    ST_STAGE = 2'b01,
    ST_RUN   = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MIN_ASSERT - 1);
  localparam logic [CNT_W-1:0] STG_LAST  = CNT_W'(STAGE_DELAY - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_n;
  logic                   flt_n;
  logic                   flt_eff;
  logic [CNT_W-1:0]       db_cnt;
  logic [7:0]             glitch_q;

  state_t                 state_q;
  state_t                 state_d;
  logic [CNT_W-1:0]       hold_cnt;
  logic [CNT_W-1:0]       hold_cnt_d;
  logic [CNT_W-1:0]       stg_cnt;
  logic [CNT_W-1:0]       stg_cnt_d;
  logic                   core_q;
  logic                   core_d;
  logic                   periph_q;
  logic                   periph_d;
  logic                   seen_q;
  logic                   pin_reset;

  // Synchroniser; idles high so POR does not look like a pin press.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], xres_n_in};
    end
  end

  assign sync_n = sync_q[SYNC_STAGES-1];

  // Debounce filter: a level change is accepted only after DEBOUNCE consecutive
  // differing samples; a run that ends early is counted as a glitch.
  always_ff @(posedge clk) begin
    if (reset) begin
      flt_n    <= 1'b1;
      db_cnt   <= '0;
      glitch_q <= '0;
    end else if (!filt_en) begin
      flt_n  <= sync_n;
      db_cnt <= '0;
    end else if (sync_n != flt_n) begin
      if (db_cnt == DB_LAST) begin
        flt_n  <= sync_n;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end else begin
      db_cnt <= '0;
      if (db_cnt != '0 && glitch_q != 8'hFF) begin
        glitch_q <= glitch_q + 8'd1;
      end
    end
  end

  // In bypass the FSM follows the synchroniser directly, saving the filter flop.
  assign flt_eff = filt_en ? flt_n : sync_n;

  // Reset sequencer next-state; outputs are computed here and registered below.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt;
    stg_cnt_d  = stg_cnt;
    core_d     = core_q;
    periph_d   = periph_q;
    pin_reset  = 1'b0;
    case (state_q)
      ST_STAGE: begin
        if (!flt_eff) begin
          state_d    = ST_HOLD;
          core_d     = 1'b0;
          periph_d   = 1'b0;
          hold_cnt_d = '0;
          pin_reset  = 1'b1;
        end else if (stg_cnt == STG_LAST) begin
          state_d  = ST_RUN;
          core_d   = 1'b1;
          periph_d = 1'b1;
        end else begin
          core_d    = 1'b1;
          periph_d  = 1'b0;
          stg_cnt_d = stg_cnt + 1'b1;
        end
      end
      ST_RUN: begin
        if (!flt_eff) begin
          state_d    = ST_HOLD;
          core_d     = 1'b0;
          periph_d   = 1'b0;
          hold_cnt_d = '0;
          pin_reset  = 1'b1;
        end else begin
          core_d   = 1'b1;
          periph_d = 1'b1;
        end
      end
      default: begin
        // HOLD, and the unused encoding which behaves as HOLD.
        state_d  = ST_HOLD;
        core_d   = 1'b0;
        periph_d = 1'b0;
        if (!flt_eff) begin
          hold_cnt_d = '0;
        end else if (hold_cnt == HOLD_LAST) begin
          state_d    = ST_STAGE;
          core_d     = 1'b1;
          stg_cnt_d  = '0;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_HOLD;
      hold_cnt <= '0;
      stg_cnt  <= '0;
      core_q   <= 1'b0;
      periph_q <= 1'b0;
      seen_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_cnt <= hold_cnt_d;
      stg_cnt  <= stg_cnt_d;
      core_q   <= core_d;
      periph_q <= periph_d;
      // A new pin reset outranks a coincident clear.
      if (pin_reset) begin
        seen_q <= 1'b1;
      end else if (xres_seen_clr) begin
        seen_q <= 1'b0;
      end
    end
  end

  assign core_rst_n   = core_q;
  assign periph_rst_n = periph_q;
  assign xres_seen    = seen_q;
  assign glitch_cnt   = glitch_q;
  assign state        = state_q;

endmodule

// File: tb/tb_xres_conditioner.sv
// Directed bench for xres_conditioner: POR sequencing, glitch rejection, pin press
// latency, bypass mode, press during STAGE, sticky flag and counter saturation.
module tb_xres_conditioner;

  logic       clk;
  logic       reset;
  logic       xres_n_in;
  logic       filt_en;
  logic       xres_seen_clr;
  logic       core_rst_n;
  logic       periph_rst_n;
  logic       xres_seen;
  logic [7:0] glitch_cnt;
  logic [1:0] state;

  int checks;
  int failures;
  logic periph_rose;

  xres_conditioner dut (
    .clk           (clk),
    .reset         (reset),
    .xres_n_in     (xres_n_in),
    .filt_en       (filt_en),
    .xres_seen_clr (xres_seen_clr),
    .core_rst_n    (core_rst_n),
    .periph_rst_n  (periph_rst_n),
    .xres_seen     (xres_seen),
    .glitch_cnt    (glitch_cnt),
    .state         (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n active edges; inputs change and outputs are sampled 1ns after an edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    reset         = 1'b1;
    xres_n_in     = 1'b1;
    filt_en       = 1'b1;
    xres_seen_clr = 1'b0;

    // 1: POR, release sequencing
    tick(3);
    check("por_core",   32'(core_rst_n),   0);
    check("por_periph", 32'(periph_rst_n), 0);
    check("por_state",  32'(state),        0);
    check("por_seen",   32'(xres_seen),    0);
    check("por_glitch", 32'(glitch_cnt),   0);
    reset = 1'b0;
    tick(63);
    check("por_core_edge63", 32'(core_rst_n), 0);
    tick(1);
    check("por_core_edge64",   32'(core_rst_n),   1);
    check("por_state_stage",   32'(state),        1);
    check("por_periph_edge64", 32'(periph_rst_n), 0);
    tick(7);
    check("por_periph_edge71", 32'(periph_rst_n), 0);
    tick(1);
    check("por_periph_edge72", 32'(periph_rst_n), 1);
    check("por_state_run",     32'(state),        2);
    check("por_seen_after",    32'(xres_seen),    0);

    // 2: 10-cycle glitch in RUN is rejected and counted
    xres_n_in = 1'b0;
    tick(10);
    xres_n_in = 1'b1;
    tick(6);
    check("glitch_core",   32'(core_rst_n),   1);
    check("glitch_periph", 32'(periph_rst_n), 1);
    check("glitch_cnt1",   32'(glitch_cnt),   1);
    check("glitch_seen",   32'(xres_seen),    0);

    // 3: valid 40-cycle press; resets fall at E+18
    xres_n_in = 1'b0;
    tick(18);
    check("press_core_e17", 32'(core_rst_n), 1);
    tick(1);
    check("press_core_e18",   32'(core_rst_n),   0);
    check("press_periph_e18", 32'(periph_rst_n), 0);
    check("press_state_e18",  32'(state),        0);
    check("press_seen",       32'(xres_seen),    1);
    tick(21);
    xres_n_in = 1'b1;
    // flt_n rises at X+17, core at X+81, periph at X+89
    tick(81);
    check("rel_core_x80", 32'(core_rst_n), 0);
    tick(1);
    check("rel_core_x81",   32'(core_rst_n),   1);
    check("rel_periph_x81", 32'(periph_rst_n), 0);
    tick(7);
    check("rel_periph_x88", 32'(periph_rst_n), 0);
    tick(1);
    check("rel_periph_x89", 32'(periph_rst_n), 1);
    check("rel_glitch",     32'(glitch_cnt),   1);

    // 4: bypass, 3-cycle low reaches the resets at E+2
    filt_en = 1'b0;
    tick(2);
    xres_n_in = 1'b0;
    tick(2);
    check("byp_core_e1", 32'(core_rst_n), 1);
    tick(1);
    check("byp_core_e2",   32'(core_rst_n),   0);
    check("byp_periph_e2", 32'(periph_rst_n), 0);
    check("byp_state_e2",  32'(state),        0);
    xres_n_in = 1'b1;
    tick(4);
    filt_en = 1'b1;
    tick(2);
    check("byp_glitch", 32'(glitch_cnt), 1);
    xres_seen_clr = 1'b1;
    tick(1);
    xres_seen_clr = 1'b0;
    check("seen_clr", 32'(xres_seen), 0);

    // 5: press landing during STAGE (fresh POR, core rises at R64, react at R68)
    reset = 1'b1;
    tick(2);
    check("por2_state",  32'(state),      0);
    check("por2_glitch", 32'(glitch_cnt), 0);
    reset = 1'b0;
    tick(49);
    xres_n_in = 1'b0;
    tick(18);
    check("stg_state_r67", 32'(state),      1);
    check("stg_core_r67",  32'(core_rst_n), 1);
    tick(1);
    check("stg_state_r68",  32'(state),        0);
    check("stg_core_r68",   32'(core_rst_n),   0);
    check("stg_periph_r68", 32'(periph_rst_n), 0);
    check("stg_seen",       32'(xres_seen),    1);
    tick(2);
    xres_n_in   = 1'b1;
    periph_rose = 1'b0;
    for (int i = 0; i < 81; i++) begin
      tick(1);
      if (periph_rst_n) periph_rose = 1'b1;
    end
    check("stg_rerun_core_x80",  32'(core_rst_n),  0);
    check("stg_rerun_no_periph", 32'(periph_rose), 0);
    tick(1);
    check("stg_rerun_core_x81", 32'(core_rst_n), 1);
    tick(7);
    check("stg_rerun_periph_x88", 32'(periph_rst_n), 0);
    tick(1);
    check("stg_rerun_periph_x89", 32'(periph_rst_n), 1);
    check("stg_rerun_state",      32'(state),        2);

    // 6a: clear coincident with a new press, set wins
    xres_seen_clr = 1'b1;
    tick(1);
    xres_seen_clr = 1'b0;
    check("sticky_clr", 32'(xres_seen), 0);
    xres_n_in = 1'b0;
    tick(18);
    xres_seen_clr = 1'b1;
    tick(1);
    xres_seen_clr = 1'b0;
    check("sticky_set_wins", 32'(xres_seen),  1);
    check("sticky_core",     32'(core_rst_n), 0);
    tick(10);
    xres_n_in = 1'b1;
    tick(20);
    check("sat_glitch0", 32'(glitch_cnt), 0);

    // 6b: 300 short glitches saturate the counter
    for (int g = 0; g < 100; g++) begin
      xres_n_in = 1'b0;
      tick(2);
      xres_n_in = 1'b1;
      tick(3);
    end
    check("sat_glitch100", 32'(glitch_cnt), 100);
    for (int g = 0; g < 200; g++) begin
      xres_n_in = 1'b0;
      tick(2);
      xres_n_in = 1'b1;
      tick(3);
    end
    tick(5);
    check("sat_glitch255", 32'(glitch_cnt), 255);

    // 6c: held low stays in HOLD, then reset mid-HOLD
    xres_n_in = 1'b0;
    tick(40);
    check("low_state",  32'(state),      0);
    check("low_glitch", 32'(glitch_cnt), 255);
    reset = 1'b1;
    tick(1);
    check("midrst_core",   32'(core_rst_n),   0);
    check("midrst_periph", 32'(periph_rst_n), 0);
    check("midrst_seen",   32'(xres_seen),    0);
    check("midrst_glitch", 32'(glitch_cnt),   0);
    check("midrst_state",  32'(state),        0);
    reset     = 1'b0;
    xres_n_in = 1'b1;
    tick(3);
    check("post_rst_core",   32'(core_rst_n), 0);
    check("post_rst_glitch", 32'(glitch_cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
